// File: rtl/cla_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice,
// stepped LSB nibble first with the carry held in a register between steps.
module cla_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [3:0] nib_a, nib_b, g, p, s4;
    logic [4:0] c;
    logic       last_nib;

    assign last_nib = (cnt_q == CW'(NIB - 1));

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
    end

    // Generate/propagate lookahead: every carry is a flat function of g, p and c[0].
    always_comb begin
        g    = nib_a & nib_b;
        p    = nib_a ^ nib_b;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s4   = p ^ c[3:0];
    end

    always_comb begin
        sum_d = sum_q;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) sum_d[4*k +: 4] = s4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c[4];
                    if (last_nib) begin
                        cout_q  <= c[4];
                        ovf_q   <= c[3] ^ c[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Directed and randomised checks of cla_serial_adder_ctrl at WIDTH=16.
module tb_cla_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout, ovf;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic         s;
        logic         ci;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    cla_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .cin  (cin),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Runs one operation from IDLE; returns edges-to-done, busy right after start, and result.
    task automatic do_op(input logic s, input logic ci, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic bz, output logic [W-1:0] rs,
                         output logic rc, output logic ro);
        sub = s; cin = ci; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bz  = busy;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        vectors++;
        if ({busy, done, cout, ovf} !== 4'b0000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t tbl [8] = '{
            '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0},
            '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1},
            '{1'b1, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0}
        };
        int           lat;
        logic         bz, rc, ro;
        logic [W-1:0] rs;
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].s, tbl[i].ci, tbl[i].av, tbl[i].bv, lat, bz, rs, rc, ro);
            vectors++;
            if (lat !== NIB || bz !== 1'b1) begin
                errors++;
                $display("FAIL arith_latency[%0d]: done after %0d edges busy=%b, required %0d edges busy=1",
                         i, lat, bz, NIB);
            end
            vectors++;
            if (rs !== tbl[i].es || rc !== tbl[i].ec || ro !== tbl[i].eo) begin
                errors++;
                $display("FAIL arith_result[%0d]: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         i, rs, rc, ro, tbl[i].es, tbl[i].ec, tbl[i].eo);
            end
        end
    endtask

    task automatic test_ignore_start();
        int           ndone = 0;
        logic [W-1:0] first = '0;
        int           lat;
        logic         bz, rc, ro;
        logic [W-1:0] rs;
        sub = 1'b0; cin = 1'b0; a = 16'h0011; b = 16'h0022; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start = (i < 5);
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                first = sum;
            end
        end
        vectors++;
        if (ndone !== 1 || first !== 16'h0033) begin
            errors++;
            $display("FAIL ignore_start: %0d done pulses sum=%h, required 1 pulse sum=0033", ndone, first);
        end
        do_op(1'b0, 1'b0, 16'h7777, 16'h1111, lat, bz, rs, rc, ro);
        vectors++;
        if (rs !== 16'h8888 || rc !== 1'b0 || ro !== 1'b1) begin
            errors++;
            $display("FAIL restart_idle: sum=%h cout=%b ovf=%b, required sum=8888 cout=0 ovf=1", rs, rc, ro);
        end
    endtask

    task automatic test_mid_reset();
        int           ndone = 0;
        int           lat;
        logic         bz, rc, ro;
        logic [W-1:0] rs;
        sub = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || sum !== 16'h0055 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_state: busy=%b sum=%h ovf=%b, required busy=1 sum=0055 ovf=1", busy, sum, ovf);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, cout, ovf} !== 4'b0000 || sum !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: %0d done pulses, required 0", ndone);
        end
        do_op(1'b0, 1'b0, 16'h00FF, 16'h0001, lat, bz, rs, rc, ro);
        vectors++;
        if (rs !== 16'h0100 || rc !== 1'b0 || ro !== 1'b0 || lat !== NIB) begin
            errors++;
            $display("FAIL post_reset_op: sum=%h cout=%b ovf=%b lat=%0d, required sum=0100 cout=0 ovf=0 lat=%0d",
                     rs, rc, ro, lat, NIB);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int n   = 0;
        int t [3];
        sub = 1'b1; cin = 1'b0; a = 16'h1000; b = 16'h0001; start = 1'b1;
        while (n < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                vectors++;
                if (sum !== 16'h0FFF || cout !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: sum=%h cout=%b, required sum=0fff cout=1", n, sum, cout);
                end
                t[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        vectors++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_count: %0d done pulses in %0d cycles, required 3", n, cyc);
        end else begin
            vectors++;
            if (t[1] - t[0] !== NIB + 2 || t[2] - t[1] !== NIB + 2) begin
                errors++;
                $display("FAIL b2b_spacing: gaps %0d,%0d, required %0d", t[1] - t[0], t[2] - t[1], NIB + 2);
            end
        end
        repeat (NIB + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int           lat;
        logic         bz, rc, ro, s, ci;
        logic [W-1:0] rs, av, bv, es, bm;
        logic [W:0]   full;
        logic         eo;
        for (int i = 0; i < 1000; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            bm   = s ? ~bv : bv;
            full = {1'b0, av} + {1'b0, bm} + {{W{1'b0}}, (s ? 1'b1 : ci)};
            es   = full[W-1:0];
            eo   = (av[W-1] == bm[W-1]) && (es[W-1] != av[W-1]);
            do_op(s, ci, av, bv, lat, bz, rs, rc, ro);
            vectors++;
            if (rs !== es || rc !== full[W] || ro !== eo || lat !== NIB) begin
                errors++;
                $display("FAIL random[%0d] sub=%b cin=%b a=%h b=%h: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                         i, s, ci, av, bv, rs, rc, ro, lat, es, full[W], eo, NIB);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cla_serial_adder_ctrl.md
Name: cla_serial_adder_ctrl

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one internal 4-bit carry-lookahead slice, least-significant nibble first, one nibble per clock.
- Carry is held in a register between nibbles.
- Gives the lab datapath wide arithmetic without instantiating WIDTH/4 lookahead slices.
- Sits between a requester (testbench, FSM or switch/button front end) and the result consumer.
- Uses a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4 (derived, localparam), number of nibble steps.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
sub  input  1  0 = a+b+cin, 1 = a-b (two's complement); sampled with start.
cin  input  1  carry-in for add mode; ignored when sub=1.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while operation in progress (RUN state).
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result register.
cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
ovf  output  1  signed overflow = carry into bit WIDTH-1 XOR cout.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset, applied at any time including mid-operation:
  - state=IDLE, nibble counter=0, carry reg=0, operand regs=0.
  - sum=0, cout=0, ovf=0, busy=0, done=0.
  - In-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a → A reg.
  - Latch (sub ? ~b : b) → B reg.
  - Carry reg ← (sub ? 1 : cin).
  - Counter ← 0; clear sum; go to RUN.
  - start=0: stay. Outputs sum/cout/ovf hold the last result.
- RUN (busy=1), each edge at counter k:
  - {c4, s4} = A[4k+3:4k] + B[4k+3:4k] + carry, via the internal generate/propagate lookahead slice, not a behavioural WIDTH-bit adder.
  - sum[4k+3:4k] ← s4; carry ← c4.
  - When k = NIB-1: capture the carry into bit 3 of that slice as c_msb; cout ← c4; ovf ← c_msb ^ c4; go to DONE.
  - Else: counter ← k+1.
- DONE: done=1 for exactly one cycle, busy=0; next edge → IDLE.
- Start handling:
  - start asserted in RUN or DONE is ignored, not queued.
  - The requester must re-assert in IDLE.
  - start held high continuously produces back-to-back operations every NIB+2 cycles.
- Latency: start sampled at edge E0; busy high after E0; done high after edge E0+NIB for one cycle; back in IDLE after E0+NIB+1.
- Operand capture: changes on a/b/sub/cin after E0 do not affect the running operation.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Sub with a=b gives sum=0, cout=1, ovf=0.
  - The counter width is clog2(NIB) and never wraps past NIB-1.
- Mid-result visibility: sum is updated nibble-by-nibble during RUN. Consumers must use it only when done=1 or in IDLE.

Test Plan:
- WIDTH=16, add, a=0x1234, b=0x4321, cin=0 → done exactly 4 cycles after start edge, sum=0x5555, cout=0, ovf=0.
- Add, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Add a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Sub, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Sub a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Start re-pulsed with different operands during RUN and DONE → ignored; first result unchanged; only one done pulse. Then start in IDLE → second result correct.
- Assert rst after 2 RUN cycles → busy, done, sum, cout and ovf go to 0 immediately (asynchronous, before next edge); no done pulse; next operation 0x00FF+0x0001 → 0x0100.
- Randomised 1000 operations, both modes, WIDTH=16 and WIDTH=32, against a reference model → sum, cout and ovf match; done spacing = NIB+2 with start held high.
